// File: rtl/vram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_arb_pkg
// Description : Shared types and helpers for the VRAM scanout/CPU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_arb_pkg;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_DISP = 2'd1,
        RD_CPU  = 2'd2
    } rd_owner_t;

    // Smallest n with 2**n >= scale; scale is limited to 1..8.
    function automatic int scale_log2(input int scale);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if ((1 << i) < scale) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_scan_arbiter
// Description : Single-port VRAM arbiter; display fetch has priority, CPU
//               takes every remaining slot. Scanout pixels replicated SCALE x.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_scan_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDRW  = 16,
    parameter int DATAW  = 8,
    parameter int SCALE  = 4,
    parameter int FB_W   = 160,
    parameter int LINE   = 799,
    parameter int SCREEN = 524,
    parameter int VA_END = 479
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic [9:0]       sx,
    input  logic [9:0]       sy,
    input  logic             de,
    output logic [ADDRW-1:0] mem_addr,
    output logic             mem_we,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             cpu_valid,
    output logic             cpu_ready,
    input  logic             cpu_we,
    input  logic [ADDRW-1:0] cpu_addr,
    input  logic [DATAW-1:0] cpu_wdata,
    output logic [DATAW-1:0] cpu_rdata,
    output logic             cpu_rvalid,
    output logic [DATAW-1:0] pix_data,
    output logic             pix_de
);

    localparam int               c_SCALE_LOG2 = scale_log2(SCALE);
    localparam logic [9:0]       c_SUB_MASK   = 10'(SCALE - 1);
    localparam logic [9:0]       c_LINE       = 10'(LINE);
    localparam logic [9:0]       c_SCREEN     = 10'(SCREEN);
    localparam logic [9:0]       c_VA_END     = 10'(VA_END);
    localparam logic [ADDRW-1:0] c_FB_W       = ADDRW'(FB_W);

    logic             w_disp_slot;
    logic             w_cpu_grant;
    logic [ADDRW-1:0] w_disp_addr;
    logic [ADDRW-1:0] r_row_base;
    logic             r_de_d1;
    rd_owner_t        r_rd_owner;
    rd_owner_t        w_rd_owner_nxt;

    // Masking rather than slicing keeps SCALE = 1 legal (no zero-width slice).
    assign w_disp_slot = de && ((sx & c_SUB_MASK) == 10'd0);
    assign w_disp_addr = r_row_base + ADDRW'(sx >> c_SCALE_LOG2);

    assign cpu_ready   = rst_pix_n && !w_disp_slot;
    assign w_cpu_grant = cpu_valid && cpu_ready;

    assign mem_addr    = w_disp_slot ? w_disp_addr : cpu_addr;
    assign mem_we      = w_cpu_grant && cpu_we;
    assign mem_wdata   = cpu_wdata;

    // Read-return owner: tags the word arriving on mem_rdata next cycle.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            r_rd_owner <= RD_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    always_comb begin
        w_rd_owner_nxt = RD_NONE;
        if (w_disp_slot) begin
            w_rd_owner_nxt = RD_DISP;
        end else if (w_cpu_grant && !cpu_we) begin
            w_rd_owner_nxt = RD_CPU;
        end
    end

    // Advance one framebuffer row after every SCALE active display lines.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            r_row_base <= '0;
        end else if (sx == c_LINE) begin
            if (sy == c_SCREEN) begin
                r_row_base <= '0;
            end else if ((sy <= c_VA_END) && ((sy & c_SUB_MASK) == c_SUB_MASK)) begin
                r_row_base <= r_row_base + c_FB_W;
            end
        end
    end

    // pix_data holds between fetches for replication and blanks with pix_de.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            r_de_d1  <= 1'b0;
            pix_de   <= 1'b0;
            pix_data <= '0;
        end else begin
            r_de_d1 <= de;
            pix_de  <= r_de_d1;
            if (r_rd_owner == RD_DISP) begin
                pix_data <= mem_rdata;
            end else if (!r_de_d1) begin
                pix_data <= '0;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= (r_rd_owner == RD_CPU);
            if (r_rd_owner == RD_CPU) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_scan_arbiter
// Description : Directed self-checking bench for vram_scan_arbiter with a
//               synchronous single-port VRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_scan_arbiter;

    logic        clk_pix = 1'b0;
    logic        rst_pix_n;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        de;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        cpu_valid;
    logic        cpu_ready;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [7:0]  pix_data;
    logic        pix_de;

    logic [7:0]  vram [0:65535];
    int          n_cmp;
    int          n_bad;

    always #5 clk_pix = ~clk_pix;

    vram_scan_arbiter dut (
        .clk_pix    (clk_pix),
        .rst_pix_n  (rst_pix_n),
        .sx         (sx),
        .sy         (sy),
        .de         (de),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .pix_data   (pix_data),
        .pix_de     (pix_de)
    );

    always @(posedge clk_pix) begin
        if (mem_we) begin
            vram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= vram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic drive(input int x, input int y, input logic d);
        sx = 10'(x);
        sy = 10'(y);
        de = d;
        #1;
    endtask

    task automatic line_end(input int y);
        drive(799, y, 1'b0);
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int n = 0; n < 65536; n++) begin
            vram[n] = 8'(n);
        end
        mem_rdata = 8'h00;

        // Reset with a pending CPU write in a non-display slot
        rst_pix_n = 1'b0;
        cpu_valid = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0040;
        cpu_wdata = 8'hEE;
        sx = 10'd1; sy = 10'd0; de = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_cpu_ready", 32'(cpu_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_pix_de", 32'(pix_de), 0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("rst_pix_data", 32'(pix_data), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);

        cpu_valid = 1'b0;
        rst_pix_n = 1'b1;
        drive(700, 0, 1'b0);
        tick();
        tick();

        // Scanout of line 0 with a CPU write colliding at sx=8
        for (int i = 0; i < 12; i++) begin
            cpu_valid = (i == 8) || (i == 9);
            cpu_we    = 1'b1;
            cpu_addr  = 16'h0100;
            cpu_wdata = 8'h5A;
            drive(i, 0, 1'b1);
            if (i == 0) check("scan_addr_sx0", 32'(mem_addr), 0);
            if (i == 4) check("scan_addr_sx4", 32'(mem_addr), 1);
            if (i == 1) check("scan_pix_de_sx1", 32'(pix_de), 0);
            if (i == 2) check("scan_pix_de_sx2", 32'(pix_de), 1);
            if (i >= 2 && i <= 5) check("scan_pix_0", 32'(pix_data), 32'h00);
            if (i >= 6 && i <= 9) check("scan_pix_1", 32'(pix_data), 32'h01);
            if (i == 8) begin
                check("coll_ready_sx8", 32'(cpu_ready), 0);
                check("coll_we_sx8", 32'(mem_we), 0);
                check("coll_addr_sx8", 32'(mem_addr), 2);
            end
            if (i == 9) begin
                check("coll_ready_sx9", 32'(cpu_ready), 1);
                check("coll_we_sx9", 32'(mem_we), 1);
                check("coll_addr_sx9", 32'(mem_addr), 32'h0100);
            end
            if (i == 10) check("scan_pix_2", 32'(pix_data), 32'h02);
            tick();
        end
        cpu_valid = 1'b0;

        // Row stepping
        line_end(0);
        line_end(1);
        line_end(2);
        check("blank_pix_de", 32'(pix_de), 0);
        check("blank_pix_data", 32'(pix_data), 0);
        drive(0, 3, 1'b1);
        check("row_sy3", 32'(mem_addr), 0);
        tick();
        line_end(3);
        drive(0, 4, 1'b1);
        check("row_sy4", 32'(mem_addr), 160);
        tick();
        drive(384, 4, 1'b1);
        check("wr_readback_addr", 32'(mem_addr), 32'h0100);
        tick();
        drive(385, 4, 1'b1);
        check("row_sy4_pix", 32'(pix_data), 32'hA0);
        tick();
        drive(386, 4, 1'b1);
        check("wr_readback_pix", 32'(pix_data), 32'h5A);
        tick();
        for (int y = 4; y < 479; y++) line_end(y);
        drive(0, 479, 1'b1);
        check("row_sy479", 32'(mem_addr), 19040);
        tick();
        for (int y = 479; y <= 524; y++) line_end(y);
        drive(0, 0, 1'b1);
        check("row_wrap", 32'(mem_addr), 0);
        tick();

        // Blanking: 8 back-to-back CPU reads, data two cycles after grant
        for (int k = 0; k < 11; k++) begin
            cpu_valid = (k < 8);
            cpu_we    = 1'b0;
            cpu_addr  = 16'(16'h2010 + k);
            drive(640 + k, 0, 1'b0);
            if (k < 8) check("blank_ready", 32'(cpu_ready), 1);
            check("blank_rvalid", 32'(cpu_rvalid), (k >= 2 && k <= 9) ? 1 : 0);
            if (k >= 2 && k <= 9) check("blank_rdata", 32'(cpu_rdata), 32'(8'(8'h10 + k - 2)));
            tick();
        end

        // Reset the cycle after a CPU read grant
        cpu_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0033;
        drive(700, 0, 1'b0);
        check("midrd_ready", 32'(cpu_ready), 1);
        tick();
        cpu_valid = 1'b0;
        rst_pix_n = 1'b0;
        #1;
        tick();
        check("midrd_rvalid", 32'(cpu_rvalid), 0);
        check("midrd_rdata", 32'(cpu_rdata), 0);
        rst_pix_n = 1'b1;
        tick();
        check("midrd_rvalid_after", 32'(cpu_rvalid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
